// File: rtl/minz_sweep_ctrl.sv
// Exhaustive sweep sequencer for the 4-input minz function: drives all 16 input
// vectors, samples z after a settle interval and scores the result against an expected table.
module minz_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_exp,
  output logic        o_a,
  output logic        o_b,
  output logic        o_c,
  output logic        o_d,
  input  logic        i_z,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [15:0] o_table,
  output logic [4:0]  o_mism_cnt,
  output logic [3:0]  o_first_err
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e      r_state, w_state_d;
  logic [3:0]  r_idx, w_idx_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [15:0] r_exp, w_exp_d;
  logic [15:0] r_table, w_table_d;
  logic [4:0]  r_mism, w_mism_d;
  logic [3:0]  r_first, w_first_d;
  logic        r_pass, w_pass_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_mism  <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_cnt   <= w_cnt_d;
      r_exp   <= w_exp_d;
      r_table <= w_table_d;
      r_mism  <= w_mism_d;
      r_first <= w_first_d;
      r_pass  <= w_pass_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_exp_d   = r_exp;
    w_table_d = r_table;
    w_mism_d  = r_mism;
    w_first_d = r_first;
    w_pass_d  = r_pass;
    case (r_state)
      StIdle: begin
        w_idx_d = '0;
        if (i_start) begin
          w_exp_d   = i_exp;
          w_cnt_d   = '0;
          w_table_d = '0;
          w_mism_d  = '0;
          w_first_d = '0;
          w_pass_d  = 1'b0;
          w_state_d = StWait;
        end
      end
      StWait: begin
        w_cnt_d = r_cnt + 4'd1;
        if (r_cnt == SettleLast) w_state_d = StSample;
      end
      StSample: begin
        w_table_d[r_idx] = i_z;
        if (i_z != r_exp[r_idx]) begin
          w_mism_d = r_mism + 5'd1;
          if (r_mism == 5'd0) w_first_d = r_idx;
        end
        if (r_idx == 4'd15) begin
          w_state_d = StDone;
        end else begin
          w_idx_d   = r_idx + 4'd1;
          w_cnt_d   = '0;
          w_state_d = StWait;
        end
      end
      StDone: begin
        // r_mism already includes the index-15 sample taken on the previous edge
        w_pass_d  = (r_mism == 5'd0);
        w_idx_d   = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign {o_a, o_b, o_c, o_d} = r_idx;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_pass      = r_pass;
  assign o_table     = r_table;
  assign o_mism_cnt  = r_mism;
  assign o_first_err = r_first;

endmodule

// File: tb/tb_minz_sweep_ctrl.sv
// Bench for minz_sweep_ctrl: a cycle-indexed reference model checks every output each cycle,
// directed sweeps pin literal results, and randomized sweeps exercise the rest.
module tb_minz_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int VEC    = SETTLE + 1;
  localparam int SWEEP  = 16 * VEC;

  typedef struct {
    logic [15:0] t;
    logic [4:0]  mc;
    logic [3:0]  fe;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_tbl = '0;
  bit          zero_mode = 1'b0;
  logic        a, b, c, d, z, busy, done, pass;
  logic [15:0] tbl;
  logic [4:0]  mism;
  logic [3:0]  first;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Environment stand-in for minz: z = (a&b)|(c&d), or stuck at 0
  assign z = zero_mode ? 1'b0 : ((a & b) | (c & d));

  minz_sweep_ctrl #(.SETTLE(SETTLE)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_exp       (exp_tbl),
    .o_a         (a),
    .o_b         (b),
    .o_c         (c),
    .o_d         (d),
    .i_z         (z),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_table     (tbl),
    .o_mism_cnt  (mism),
    .o_first_err (first)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Results after the first n vectors have been scored
  function automatic res_t results(input int n, input logic [15:0] e, input bit zm);
    res_t       r;
    logic [3:0] k4;
    logic       bz;
    r.t  = '0;
    r.mc = '0;
    r.fe = '0;
    for (int k = 0; k < n; k++) begin
      k4 = 4'(k);
      bz = zm ? 1'b0 : ((k4[3] & k4[2]) | (k4[1] & k4[0]));
      r.t[k4] = bz;
      if (bz != e[k4]) begin
        if (r.mc == 5'd0) r.fe = k4;
        r.mc = r.mc + 5'd1;
      end
    end
    return r;
  endfunction

  function automatic bit all_match(input logic [15:0] e, input bit zm);
    res_t r;
    r = results(16, e, zm);
    return (r.mc == 5'd0);
  endfunction

  // Model: m_t = cycles since the accepting edge while a sweep is in flight
  bit          m_busy = 1'b0;
  int          m_t = 0;
  logic [15:0] m_exp = '0;
  bit          m_zero = 1'b0;
  int          m_n_idle = 0;
  bit          m_pass = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_t      <= 0;
      m_exp    <= '0;
      m_zero   <= 1'b0;
      m_n_idle <= 0;
      m_pass   <= 1'b0;
    end else if (m_busy) begin
      if (m_t == SWEEP) begin
        m_busy   <= 1'b0;
        m_n_idle <= 16;
        m_pass   <= all_match(m_exp, m_zero);
      end else begin
        m_t <= m_t + 1;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_t    <= 0;
      m_exp  <= exp_tbl;
      m_zero <= zero_mode;
      m_pass <= 1'b0;
    end
  end

  task automatic compare_cycle();
    int   n, ix;
    res_t r;
    n  = m_busy ? (((m_t / VEC) > 16) ? 16 : (m_t / VEC)) : m_n_idle;
    ix = m_busy ? ((m_t < SWEEP) ? (m_t / VEC) : 15) : 0;
    r  = results(n, m_exp, m_zero);
    check("stim",      32'({a, b, c, d}), 32'(ix));
    check("busy",      32'(busy),  32'(m_busy));
    check("done",      32'(done),  32'(m_busy && (m_t == SWEEP)));
    check("pass",      32'(pass),  32'(!m_busy && m_pass));
    check("table",     32'(tbl),   32'(r.t));
    check("mism_cnt",  32'(mism),  32'(r.mc));
    check("first_err", 32'(first), 32'(r.fe));
  endtask

  always @(negedge clk) if (rst_n) compare_cycle();

  task automatic check_reset(input string tag);
    check({tag, "_stim"},  32'({a, b, c, d}), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_pass"},  32'(pass), 0);
    check({tag, "_table"}, 32'(tbl), 0);
    check({tag, "_mism"},  32'(mism), 0);
    check({tag, "_first"}, 32'(first), 0);
  endtask

  // One sweep; start is re-pulsed mid-sweep at edges p1/p2 (-1 = never).
  // lat = number of the edge, counted from the accepting edge 0, that samples done high.
  task automatic sweep(input logic [15:0] e, input bit zm, input int p1, input int p2,
                       output int lat);
    int ed;
    @(negedge clk);
    exp_tbl   = e;
    zero_mode = zm;
    start     = 1'b1;
    @(negedge clk);
    ed  = 0;
    lat = -1;
    while (lat < 0 && ed < 200) begin
      start = (ed == p1) || (ed == p2);
      if (done) begin
        lat = ed + 1;
      end else begin
        @(negedge clk);
        ed++;
      end
    end
    start = 1'b0;
    if (lat < 0) check("done_seen", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int   lat;
    int   cyc, d1, d2, d3;
    bit   found;
    logic [15:0] e;
    bit   zm;
    int   p1;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    check_reset("rst_init");
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_stim", 32'({a, b, c, d}), 0);
    check("idle_busy", 32'(busy), 0);
    #3 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk) rst_n = 1'b1;

    // Directed sweeps with literal expectations
    sweep(16'hF888, 1'b0, -1, -1, lat);
    check("pass_lat", 32'(lat), 49);
    check("pass_table", 32'(tbl), 32'h0000_F888);
    check("pass_pass", 32'(pass), 1);
    check("pass_mism", 32'(mism), 0);
    check("pass_first", 32'(first), 0);

    sweep(16'hF889, 1'b0, -1, -1, lat);
    check("one_pass", 32'(pass), 0);
    check("one_mism", 32'(mism), 1);
    check("one_first", 32'(first), 0);
    check("one_table", 32'(tbl), 32'h0000_F888);

    sweep(16'h8001, 1'b1, -1, -1, lat);
    check("two_mism", 32'(mism), 2);
    check("two_first", 32'(first), 0);
    check("two_table", 32'(tbl), 0);

    sweep(16'h8000, 1'b1, -1, -1, lat);
    check("last_mism", 32'(mism), 1);
    check("last_first", 32'(first), 15);

    sweep(16'hFFFF, 1'b1, -1, -1, lat);
    check("all_mism", 32'(mism), 16);
    check("all_pass", 32'(pass), 0);

    // Start pulses mid-sweep are ignored
    sweep(16'hF888, 1'b0, 3 * VEC, 9 * VEC, lat);
    check("ign_lat", 32'(lat), 49);
    check("ign_pass", 32'(pass), 1);

    // Start held high: back-to-back sweeps
    @(negedge clk);
    exp_tbl   = 16'hF808;
    zero_mode = 1'b0;
    start     = 1'b1;
    cyc = 0; d1 = -1; d2 = -1; d3 = -1;
    for (int i = 0; i < 400 && d3 < 0; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
        else d3 = cyc;
      end
    end
    check("hold_period1", 32'(d2 - d1), 50);
    check("hold_period2", 32'(d3 - d2), 50);
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("hold_idle", 32'(busy), 0);

    // Reset mid-sweep at vector 7
    @(negedge clk);
    exp_tbl = 16'hF888;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if ({a, b, c, d} == 4'd7) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_idx7", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    sweep(16'hF888, 1'b0, -1, -1, lat);
    check("post_rst_pass", 32'(pass), 1);
    check("post_rst_table", 32'(tbl), 32'h0000_F888);

    // Randomized sweeps checked by the per-cycle model
    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 2))
        0:       e = 16'($urandom);
        1:       e = 16'hF888 ^ (16'h1 << $urandom_range(0, 15));
        default: e = 16'hF888;
      endcase
      zm = ($urandom_range(0, 3) == 0);
      p1 = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, SWEEP));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sweep(e, zm, p1, -1, lat);
      check("rand_lat", 32'(lat), 49);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
